// File: rtl/control_unit.sv
// Main decoder and ALU-control decoder for the single-cycle RV32I core.
// Decode is combinational and the resulting control word is registered once.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Jump,
  output logic       Branch,
  output logic       ALUSrc,
  output logic       MemToReg,
  output logic [2:0] ImmSel,
  output logic [3:0] ALUCtrl
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  logic     w_reg_write;
  logic     w_mem_read;
  logic     w_mem_write;
  logic     w_jump;
  logic     w_branch;
  logic     w_alu_src;
  logic     w_mem_to_reg;
  imm_sel_e w_imm_sel;
  alu_op_e  w_alu_ctrl;
  alu_op_e  w_alu_f3;
  logic     w_f7_valid;
  logic     w_f3_valid;
  logic     w_illegal;

  logic       r_reg_write;
  logic       r_mem_read;
  logic       r_mem_write;
  logic       r_jump;
  logic       r_branch;
  logic       r_alu_src;
  logic       r_mem_to_reg;
  logic [2:0] r_imm_sel;
  logic [3:0] r_alu_ctrl;

  // Shared funct3 map for R/I ALU ops; unknown funct bits flag the word illegal.
  always_comb begin
    w_f7_valid = 1'b0;
    case (funct7_5)
      1'b0, 1'b1: w_f7_valid = 1'b1;
      default:    w_f7_valid = 1'b0;
    endcase
    w_f3_valid = 1'b1;
    w_alu_f3   = ALU_ADD;
    case (funct3)
      3'b000:  w_alu_f3 = ALU_ADD;
      3'b001:  w_alu_f3 = ALU_SLL;
      3'b010:  w_alu_f3 = ALU_SLT;
      3'b011:  w_alu_f3 = ALU_SLTU;
      3'b100:  w_alu_f3 = ALU_XOR;
      3'b101:  w_alu_f3 = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_f3 = ALU_OR;
      3'b111:  w_alu_f3 = ALU_AND;
      default: w_f3_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_jump       = 1'b0;
    w_branch     = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_imm_sel    = IMM_I;
    w_alu_ctrl   = ALU_ADD;
    w_illegal    = 1'b0;
    case (opcode)
      OP_R: begin
        w_reg_write = 1'b1;
        w_alu_ctrl  = (funct3 == 3'b000 && funct7_5) ? ALU_SUB : w_alu_f3;
        w_illegal   = !w_f3_valid || ((funct3 == 3'b000 || funct3 == 3'b101) && !w_f7_valid);
      end
      OP_I: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctrl  = w_alu_f3;
        w_illegal   = !w_f3_valid || (funct3 == 3'b101 && !w_f7_valid);
      end
      OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_alu_src    = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_sel   = IMM_S;
      end
      OP_BRANCH: begin
        w_branch  = 1'b1;
        w_imm_sel = IMM_B;
        case (funct3)
          3'b000, 3'b001: w_alu_ctrl = ALU_SUB;
          3'b100, 3'b101: w_alu_ctrl = ALU_SLT;
          3'b110, 3'b111: w_alu_ctrl = ALU_SLTU;
          default:        w_illegal  = 1'b1;
        endcase
      end
      OP_JAL: begin
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_imm_sel   = IMM_J;
      end
      OP_JALR: begin
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_alu_src   = 1'b1;
      end
      OP_LUI: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_sel   = IMM_U;
        w_alu_ctrl  = ALU_PASSB;
      end
      OP_AUIPC: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_sel   = IMM_U;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_reg_write  = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_jump       = 1'b0;
      w_branch     = 1'b0;
      w_alu_src    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_imm_sel    = IMM_I;
      w_alu_ctrl   = ALU_ADD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_jump       <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_imm_sel    <= '0;
      r_alu_ctrl   <= '0;
    end else begin
      r_reg_write  <= w_reg_write;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_jump       <= w_jump;
      r_branch     <= w_branch;
      r_alu_src    <= w_alu_src;
      r_mem_to_reg <= w_mem_to_reg;
      r_imm_sel    <= w_imm_sel;
      r_alu_ctrl   <= w_alu_ctrl;
    end
  end

  assign RegWrite = r_reg_write;
  assign MemRead  = r_mem_read;
  assign MemWrite = r_mem_write;
  assign Jump     = r_jump;
  assign Branch   = r_branch;
  assign ALUSrc   = r_alu_src;
  assign MemToReg = r_mem_to_reg;
  assign ImmSel   = r_imm_sel;
  assign ALUCtrl  = r_alu_ctrl;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; control word packed as
// {RegWrite,MemRead,MemWrite,Jump,Branch,ALUSrc,MemToReg,ImmSel,ALUCtrl}.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       RegWrite, MemRead, MemWrite, Jump, Branch, ALUSrc, MemToReg;
  logic [2:0] ImmSel;
  logic [3:0] ALUCtrl;
  logic [13:0] w_out;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Jump(Jump),
    .Branch(Branch), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .ImmSel(ImmSel), .ALUCtrl(ALUCtrl)
  );

  always #5 clk = ~clk;

  assign w_out = {RegWrite, MemRead, MemWrite, Jump, Branch, ALUSrc, MemToReg, ImmSel, ALUCtrl};

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    @(negedge clk);
    opcode = op; funct3 = f3; funct7_5 = f7;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    set_in(op, f3, f7);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_in(7'b0110011, 3'b000, 1'b0);
    #1;
    n_checks++;
    if (w_out !== 14'b0) begin
      n_fail++; $display("FAIL reset_low: got %b want %b", w_out, 14'b0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (w_out !== 14'b0) begin
      n_fail++; $display("FAIL reset_held: got %b want %b", w_out, 14'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (w_out !== {7'b1000000, 3'b000, 4'b0000}) begin
      n_fail++; $display("FAIL reset_release_rtype: got %b want %b", w_out, {7'b1000000, 3'b000, 4'b0000});
    end
  endtask

  task automatic test_rtype;
    drive(7'b0110011, 3'b000, 1'b0);
    n_checks++;
    if (w_out !== {7'b1000000, 3'b000, 4'b0000}) begin
      n_fail++; $display("FAIL r_add: got %b want %b", w_out, {7'b1000000, 3'b000, 4'b0000});
    end
    drive(7'b0110011, 3'b000, 1'b1);
    n_checks++;
    if (w_out !== {7'b1000000, 3'b000, 4'b0001}) begin
      n_fail++; $display("FAIL r_sub: got %b want %b", w_out, {7'b1000000, 3'b000, 4'b0001});
    end
    drive(7'b0110011, 3'b101, 1'b1);
    n_checks++;
    if (w_out !== {7'b1000000, 3'b000, 4'b0111}) begin
      n_fail++; $display("FAIL r_sra: got %b want %b", w_out, {7'b1000000, 3'b000, 4'b0111});
    end
    drive(7'b0110011, 3'b011, 1'b0);
    n_checks++;
    if (w_out !== {7'b1000000, 3'b000, 4'b1001}) begin
      n_fail++; $display("FAIL r_sltu: got %b want %b", w_out, {7'b1000000, 3'b000, 4'b1001});
    end
    drive(7'b0110011, 3'b111, 1'b0);
    n_checks++;
    if (w_out !== {7'b1000000, 3'b000, 4'b0010}) begin
      n_fail++; $display("FAIL r_and: got %b want %b", w_out, {7'b1000000, 3'b000, 4'b0010});
    end
  endtask

  task automatic test_itype;
    drive(7'b0010011, 3'b000, 1'b1);
    n_checks++;
    if (w_out !== {7'b1000010, 3'b000, 4'b0000}) begin
      n_fail++; $display("FAIL i_addi_f7: got %b want %b", w_out, {7'b1000010, 3'b000, 4'b0000});
    end
    drive(7'b0010011, 3'b110, 1'b0);
    n_checks++;
    if (w_out !== {7'b1000010, 3'b000, 4'b0011}) begin
      n_fail++; $display("FAIL i_ori: got %b want %b", w_out, {7'b1000010, 3'b000, 4'b0011});
    end
    drive(7'b0010011, 3'b101, 1'b1);
    n_checks++;
    if (w_out !== {7'b1000010, 3'b000, 4'b0111}) begin
      n_fail++; $display("FAIL i_srai: got %b want %b", w_out, {7'b1000010, 3'b000, 4'b0111});
    end
    drive(7'b0010011, 3'b101, 1'b0);
    n_checks++;
    if (w_out !== {7'b1000010, 3'b000, 4'b0110}) begin
      n_fail++; $display("FAIL i_srli: got %b want %b", w_out, {7'b1000010, 3'b000, 4'b0110});
    end
    drive(7'b0010011, 3'b001, 1'b0);
    n_checks++;
    if (w_out !== {7'b1000010, 3'b000, 4'b0101}) begin
      n_fail++; $display("FAIL i_slli: got %b want %b", w_out, {7'b1000010, 3'b000, 4'b0101});
    end
  endtask

  task automatic test_memory;
    drive(7'b0000011, 3'b010, 1'b0);
    n_checks++;
    if (w_out !== {7'b1100011, 3'b000, 4'b0000}) begin
      n_fail++; $display("FAIL lw: got %b want %b", w_out, {7'b1100011, 3'b000, 4'b0000});
    end
    drive(7'b0000011, 3'b101, 1'b1);
    n_checks++;
    if (w_out !== {7'b1100011, 3'b000, 4'b0000}) begin
      n_fail++; $display("FAIL lhu_f3_ignored: got %b want %b", w_out, {7'b1100011, 3'b000, 4'b0000});
    end
    drive(7'b0100011, 3'b010, 1'b0);
    n_checks++;
    if (w_out !== {7'b0010010, 3'b001, 4'b0000}) begin
      n_fail++; $display("FAIL sw: got %b want %b", w_out, {7'b0010010, 3'b001, 4'b0000});
    end
  endtask

  task automatic test_branch;
    logic [3:0]  alu_tab [8];
    logic [13:0] exp;
    alu_tab = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1001, 4'b1001};
    for (int i = 0; i < 8; i++) begin
      drive(7'b1100011, 3'(i), 1'b0);
      exp = (i == 2 || i == 3) ? 14'b0 : {7'b0000100, 3'b010, alu_tab[i]};
      n_checks++;
      if (w_out !== exp) begin
        n_fail++; $display("FAIL branch_f3_%0d: got %b want %b", i, w_out, exp);
      end
    end
  endtask

  task automatic test_jump_u_default;
    drive(7'b1101111, 3'b000, 1'b0);
    n_checks++;
    if (w_out !== {7'b1001000, 3'b100, 4'b0000}) begin
      n_fail++; $display("FAIL jal: got %b want %b", w_out, {7'b1001000, 3'b100, 4'b0000});
    end
    drive(7'b1100111, 3'b011, 1'b0);
    n_checks++;
    if (w_out !== {7'b1001010, 3'b000, 4'b0000}) begin
      n_fail++; $display("FAIL jalr: got %b want %b", w_out, {7'b1001010, 3'b000, 4'b0000});
    end
    drive(7'b0110111, 3'b000, 1'b0);
    n_checks++;
    if (w_out !== {7'b1000010, 3'b011, 4'b1010}) begin
      n_fail++; $display("FAIL lui: got %b want %b", w_out, {7'b1000010, 3'b011, 4'b1010});
    end
    drive(7'b0010111, 3'b000, 1'b0);
    n_checks++;
    if (w_out !== {7'b1000010, 3'b011, 4'b0000}) begin
      n_fail++; $display("FAIL auipc: got %b want %b", w_out, {7'b1000010, 3'b011, 4'b0000});
    end
    drive(7'b1111111, 3'b111, 1'b1);
    n_checks++;
    if (w_out !== 14'b0) begin
      n_fail++; $display("FAIL default_op: got %b want %b", w_out, 14'b0);
    end
  endtask

  task automatic test_back_to_back;
    drive(7'b0000011, 3'b010, 1'b0);
    set_in(7'b0100011, 3'b010, 1'b0);
    #1;
    n_checks++;
    if (w_out !== {7'b1100011, 3'b000, 4'b0000}) begin
      n_fail++; $display("FAIL latency_hold: got %b want %b", w_out, {7'b1100011, 3'b000, 4'b0000});
    end
    @(posedge clk); #1;
    n_checks++;
    if (w_out !== {7'b0010010, 3'b001, 4'b0000}) begin
      n_fail++; $display("FAIL latency_update: got %b want %b", w_out, {7'b0010010, 3'b001, 4'b0000});
    end
  endtask

  task automatic test_mid_reset;
    drive(7'b1101111, 3'b000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_out !== 14'b0) begin
      n_fail++; $display("FAIL async_reset: got %b want %b", w_out, 14'b0);
    end
    drive(7'b0110111, 3'b000, 1'b0);
    n_checks++;
    if (w_out !== 14'b0) begin
      n_fail++; $display("FAIL reset_beats_clock: got %b want %b", w_out, 14'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (w_out !== {7'b1000010, 3'b011, 4'b1010}) begin
      n_fail++; $display("FAIL post_reset_lui: got %b want %b", w_out, {7'b1000010, 3'b011, 4'b1010});
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_itype;
    test_memory;
    test_branch;
    test_jump_u_default;
    test_back_to_back;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
